// File: rtl/dsp_mult_pipe.sv
// Pipelined, mode-configurable unsigned DSP multiplier (dual 19x18, 27x27, quad 9x9, 27x27 MAC)
// built from 9x9 / 10x9 primitives, with a valid/ready handshake and a global stall enable.
module dsp_mult_pipe #(
    parameter int LATENCY = 3,
    parameter int ACC_W   = 74
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic             acc_clr,
    input  logic [36:0]      IN1,
    input  logic [36:0]      IN2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [1:0]       out_mode
);

    localparam logic [1:0] MODE_DUAL  = 2'b00;
    localparam logic [1:0] MODE_MUL27 = 2'b01;
    localparam logic [1:0] MODE_QUAD  = 2'b10;
    localparam logic [1:0] MODE_MAC   = 2'b11;

    function automatic logic [17:0] mul9(input logic [8:0] a, input logic [8:0] b);
        return {9'd0, a} * {9'd0, b};
    endfunction

    function automatic logic [18:0] mul10x9(input logic [9:0] a, input logic [8:0] b);
        return {9'd0, a} * {10'd0, b};
    endfunction

    // 19-bit operand splits 10+9, 18-bit operand splits 9+9.
    function automatic logic [36:0] mul19x18(input logic [18:0] a, input logic [17:0] b);
        logic [17:0] ll;
        logic [17:0] lh;
        logic [18:0] hl;
        logic [18:0] hh;
        ll = mul9(a[8:0], b[8:0]);
        lh = mul9(a[8:0], b[17:9]);
        hl = mul10x9(a[18:9], b[8:0]);
        hh = mul10x9(a[18:9], b[17:9]);
        return 37'(ll) + (37'(lh) << 9) + (37'(hl) << 9) + (37'(hh) << 18);
    endfunction

    function automatic logic [53:0] mul27(input logic [26:0] a, input logic [26:0] b);
        logic [53:0] sum;
        sum = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                sum = sum + (54'(mul9(a[9*i +: 9], b[9*j +: 9])) << (9 * (i + j)));
            end
        end
        return sum;
    endfunction

    logic [36:0]      p1;
    logic [36:0]      p2;
    logic [53:0]      p27;
    logic [17:0]      q0;
    logic [17:0]      q1;
    logic [17:0]      q2;
    logic [17:0]      q3;
    logic [ACC_W-1:0] res_comb;

    always_comb begin
        p1  = mul19x18(IN1[18:0], IN1[36:19]);
        p2  = mul19x18(IN2[18:0], IN2[36:19]);
        p27 = mul27(IN1[26:0], IN2[26:0]);
        q0  = mul9(IN1[8:0],   IN1[17:9]);
        q1  = mul9(IN1[26:18], IN1[35:27]);
        q2  = mul9(IN2[8:0],   IN2[17:9]);
        q3  = mul9(IN2[26:18], IN2[35:27]);
        res_comb = '0;
        case (mode)
            MODE_DUAL:  res_comb[73:0] = {p2, p1};
            MODE_QUAD:  res_comb[71:0] = {q3, q2, q1, q0};
            MODE_MUL27: res_comb[53:0] = p27;
            default:    res_comb[53:0] = p27;
        endcase
    end

    logic             stg_valid_q [LATENCY];
    logic             stg_valid_d [LATENCY];
    logic [1:0]       stg_mode_q  [LATENCY];
    logic [1:0]       stg_mode_d  [LATENCY];
    logic             stg_clr_q   [LATENCY];
    logic             stg_clr_d   [LATENCY];
    logic [ACC_W-1:0] stg_data_q  [LATENCY];
    logic [ACC_W-1:0] stg_data_d  [LATENCY];

    logic             inc_valid [LATENCY];
    logic [1:0]       inc_mode  [LATENCY];
    logic             inc_clr   [LATENCY];
    logic [ACC_W-1:0] inc_data  [LATENCY];

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] mac_sum;
    logic             en;

    assign out_valid = stg_valid_q[LATENCY-1];
    assign out_mode  = stg_mode_q[LATENCY-1];
    assign out_data  = stg_data_q[LATENCY-1];
    assign en        = !(out_valid && !out_ready);
    assign in_ready  = en;

    // Bubbles enter as all-zero so idle stages never expose stale operands.
    // MAC products ride the pipe raw and are folded into the accumulator on entry to the last stage.
    always_comb begin
        inc_valid[0] = in_valid;
        inc_mode[0]  = in_valid ? mode : MODE_DUAL;
        inc_clr[0]   = in_valid & acc_clr;
        inc_data[0]  = in_valid ? res_comb : '0;
        for (int k = 1; k < LATENCY; k++) begin
            inc_valid[k] = stg_valid_q[k-1];
            inc_mode[k]  = stg_mode_q[k-1];
            inc_clr[k]   = stg_clr_q[k-1];
            inc_data[k]  = stg_data_q[k-1];
        end

        mac_sum = (inc_clr[LATENCY-1] ? '0 : acc_q) + inc_data[LATENCY-1];
        acc_d   = acc_q;
        for (int k = 0; k < LATENCY; k++) begin
            stg_valid_d[k] = en ? inc_valid[k] : stg_valid_q[k];
            stg_mode_d[k]  = en ? inc_mode[k]  : stg_mode_q[k];
            stg_clr_d[k]   = en ? inc_clr[k]   : stg_clr_q[k];
            stg_data_d[k]  = en ? inc_data[k]  : stg_data_q[k];
        end
        if (en && inc_valid[LATENCY-1] && inc_mode[LATENCY-1] == MODE_MAC) begin
            stg_data_d[LATENCY-1] = mac_sum;
            acc_d                 = mac_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                stg_valid_q[k] <= 1'b0;
                stg_mode_q[k]  <= MODE_DUAL;
                stg_clr_q[k]   <= 1'b0;
                stg_data_q[k]  <= '0;
            end
            acc_q <= '0;
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                stg_valid_q[k] <= stg_valid_d[k];
                stg_mode_q[k]  <= stg_mode_d[k];
                stg_clr_q[k]   <= stg_clr_d[k];
                stg_data_q[k]  <= stg_data_d[k];
            end
            acc_q <= acc_d;
        end
    end

endmodule

// File: tb/tb_dsp_mult_pipe.sv
// Directed testbench for dsp_mult_pipe (LATENCY=3, ACC_W=74): each task drives one scenario
// and checks the results against hand-computed values.
module tb_dsp_mult_pipe;

    localparam int AW = 74;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    mode;
    logic          acc_clr;
    logic [36:0]   in1;
    logic [36:0]   in2;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic [1:0]    out_mode;

    int checks = 0;
    int errors = 0;

    logic [36:0]   v_in1   [8];
    logic [36:0]   v_in2   [8];
    logic [1:0]    v_mode  [8];
    logic          v_clr   [8];
    logic [AW-1:0] got_data[8];
    logic [1:0]    got_mode[8];
    int            got_cyc [8];
    int            got_cnt;
    int            hold_bad;
    int            ready_bad;
    int            stall_seen;

    always #5 clk = ~clk;

    dsp_mult_pipe #(.LATENCY(3), .ACC_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .acc_clr   (acc_clr),
        .IN1       (in1),
        .IN2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode)
    );

    task automatic set_vec(input int i, input logic [36:0] a, input logic [36:0] b,
                           input logic [1:0] m, input logic c);
        v_in1[i]  = a;
        v_in2[i]  = b;
        v_mode[i] = m;
        v_clr[i]  = c;
    endtask

    // Streams n vectors, holding out_ready low for stall_len cycles from stall_start,
    // and records every output transfer plus stall-behaviour observations.
    task automatic stream(input int n, input int stall_start, input int stall_len);
        int            sent;
        logic          prev_stall;
        logic [AW-1:0] prev_data;
        sent = 0; got_cnt = 0; hold_bad = 0; ready_bad = 0; stall_seen = 0;
        prev_stall = 1'b0; prev_data = '0;
        for (int cyc = 0; cyc < 60 && got_cnt < n; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
            #1;
            if (prev_stall && (!out_valid || out_data !== prev_data)) hold_bad++;
            if (in_ready !== !(out_valid && !out_ready)) ready_bad++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (prev_stall) stall_seen++;
            if (out_valid && out_ready && got_cnt < 8) begin
                got_data[got_cnt] = out_data;
                got_mode[got_cnt] = out_mode;
                got_cyc[got_cnt]  = cyc;
                got_cnt++;
            end
            if (sent < n && in_ready) begin
                in_valid = 1'b1;
                in1      = v_in1[sent];
                in2      = v_in2[sent];
                mode     = v_mode[sent];
                acc_clr  = v_clr[sent];
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", out_data); end
        checks++; if (out_mode !== 2'b00) begin errors++; $display("[TB] FAIL reset_mode: got %b expected 00", out_mode); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_dual();
        int            lat;
        logic [AW-1:0] d;
        logic [1:0]    m;
        logic [AW-1:0] exp_big;
        lat = 0; d = '0; m = 2'b11;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; mode = 2'b00; acc_clr = 1'b0;
        in1 = {18'd3, 19'd5}; in2 = {18'd2, 19'd7};
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid) begin lat = i; d = out_data; m = out_mode; end
        end
        checks++; if (lat != 3) begin errors++; $display("[TB] FAIL dual_latency: got %0d expected 3", lat); end
        checks++; if (d !== ((74'd14 << 37) | 74'd15)) begin errors++; $display("[TB] FAIL dual_data: got %h expected %h", d, (74'd14 << 37) | 74'd15); end
        checks++; if (m !== 2'b00) begin errors++; $display("[TB] FAIL dual_mode: got %b expected 00", m); end

        exp_big = (74'd300000000 << 37) | ((74'd1 << 37) - (74'd1 << 19) - (74'd1 << 18) + 74'd1);
        set_vec(0, {18'h3FFFF, 19'h7FFFF}, {18'd1000, 19'd300000}, 2'b00, 1'b0);
        set_vec(1, {18'd3, 19'd5}, {18'd2, 19'd7}, 2'b00, 1'b0);
        stream(2, 100, 0);
        checks++; if (got_cnt != 2) begin errors++; $display("[TB] FAIL dual_count: got %0d expected 2", got_cnt); end
        checks++; if (got_data[0] !== exp_big) begin errors++; $display("[TB] FAIL dual_big: got %h expected %h", got_data[0], exp_big); end
        checks++; if (got_data[1] !== ((74'd14 << 37) | 74'd15)) begin errors++; $display("[TB] FAIL dual_b2b: got %h expected %h", got_data[1], (74'd14 << 37) | 74'd15); end
    endtask

    task automatic test_mul27();
        logic [AW-1:0] exp_max;
        exp_max = (74'd1 << 54) - (74'd1 << 28) + 74'd1;
        set_vec(0, {10'd0, 27'h7FFFFFF}, {10'd0, 27'h7FFFFFF}, 2'b01, 1'b0);
        set_vec(1, {10'h3FF, 27'd123456}, {10'h155, 27'd654321}, 2'b01, 1'b0);
        stream(2, 100, 0);
        checks++; if (got_cnt != 2) begin errors++; $display("[TB] FAIL mul27_count: got %0d expected 2", got_cnt); end
        checks++; if (got_data[0] !== exp_max) begin errors++; $display("[TB] FAIL mul27_max: got %h expected %h", got_data[0], exp_max); end
        checks++; if (got_data[1] !== 74'd80779853376) begin errors++; $display("[TB] FAIL mul27_mixed: got %0d expected 80779853376", got_data[1]); end
        checks++; if (got_mode[0] !== 2'b01) begin errors++; $display("[TB] FAIL mul27_mode: got %b expected 01", got_mode[0]); end
    endtask

    task automatic test_quad();
        logic [AW-1:0] exp_q;
        exp_q = (74'd90 << 54) | (74'd56 << 36) | (74'd30 << 18) | 74'd12;
        set_vec(0, {1'b1, 9'd6, 9'd5, 9'd4, 9'd3}, {1'b1, 9'd10, 9'd9, 9'd8, 9'd7}, 2'b10, 1'b0);
        stream(1, 100, 0);
        checks++; if (got_cnt != 1) begin errors++; $display("[TB] FAIL quad_count: got %0d expected 1", got_cnt); end
        checks++; if (got_data[0] !== exp_q) begin errors++; $display("[TB] FAIL quad_data: got %h expected %h", got_data[0], exp_q); end
        checks++; if (got_data[0][73:72] !== 2'b00) begin errors++; $display("[TB] FAIL quad_top_bits: got %b expected 00", got_data[0][73:72]); end
        checks++; if (got_mode[0] !== 2'b10) begin errors++; $display("[TB] FAIL quad_mode: got %b expected 10", got_mode[0]); end
    endtask

    task automatic test_back_to_back_mac();
        logic [AW-1:0] exp_d [6];
        logic [1:0]    exp_m [6];
        exp_d = '{74'd100, 74'd160, 74'd4, 74'd1, 74'd16, 74'd10};
        exp_m = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b11};
        set_vec(0, 37'd10, 37'd10, 2'b11, 1'b1);
        set_vec(1, 37'd20, 37'd3,  2'b11, 1'b0);
        set_vec(2, 37'd2,  37'd2,  2'b01, 1'b0);
        set_vec(3, 37'd1,  37'd1,  2'b11, 1'b1);
        set_vec(4, 37'd4,  37'd4,  2'b01, 1'b0);
        set_vec(5, 37'd3,  37'd3,  2'b11, 1'b0);
        stream(6, 100, 0);
        checks++; if (got_cnt != 6) begin errors++; $display("[TB] FAIL mac_count: got %0d expected 6", got_cnt); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (got_data[i] !== exp_d[i]) begin errors++; $display("[TB] FAIL mac_data[%0d]: got %0d expected %0d", i, got_data[i], exp_d[i]); end
            checks++; if (got_mode[i] !== exp_m[i]) begin errors++; $display("[TB] FAIL mac_mode[%0d]: got %b expected %b", i, got_mode[i], exp_m[i]); end
        end
        checks++; if (got_cyc[1] - got_cyc[0] != 1) begin errors++; $display("[TB] FAIL mac_gap: got %0d expected 1", got_cyc[1] - got_cyc[0]); end
    endtask

    task automatic test_stall();
        int extra;
        extra = 0;
        set_vec(0, 37'd3,  37'd5,  2'b01, 1'b0);
        set_vec(1, 37'd7,  37'd11, 2'b01, 1'b0);
        set_vec(2, 37'd13, 37'd17, 2'b01, 1'b0);
        stream(3, 3, 5);
        checks++; if (got_cnt != 3) begin errors++; $display("[TB] FAIL stall_count: got %0d expected 3", got_cnt); end
        checks++; if (stall_seen != 5) begin errors++; $display("[TB] FAIL stall_cycles: got %0d expected 5", stall_seen); end
        checks++; if (hold_bad != 0) begin errors++; $display("[TB] FAIL stall_hold: got %0d unstable cycles expected 0", hold_bad); end
        checks++; if (ready_bad != 0) begin errors++; $display("[TB] FAIL stall_in_ready: got %0d wrong cycles expected 0", ready_bad); end
        checks++; if (got_data[0] !== 74'd15) begin errors++; $display("[TB] FAIL stall_data0: got %0d expected 15", got_data[0]); end
        checks++; if (got_data[1] !== 74'd77) begin errors++; $display("[TB] FAIL stall_data1: got %0d expected 77", got_data[1]); end
        checks++; if (got_data[2] !== 74'd221) begin errors++; $display("[TB] FAIL stall_data2: got %0d expected 221", got_data[2]); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("[TB] FAIL stall_duplicate: got %0d extra outputs expected 0", extra); end
    endtask

    task automatic test_reset_mid();
        int leaked;
        leaked = 0;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; mode = 2'b11; acc_clr = 1'b1; in1 = 37'd6; in2 = 37'd7;
        @(negedge clk);
        acc_clr = 1'b0; in1 = 37'd8; in2 = 37'd9;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL midreset_data: got %h expected 0", out_data); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) leaked++;
        end
        checks++; if (leaked != 0) begin errors++; $display("[TB] FAIL midreset_flush: got %0d outputs expected 0", leaked); end
        set_vec(0, 37'd5, 37'd5, 2'b11, 1'b0);
        stream(1, 100, 0);
        checks++; if (got_cnt != 1) begin errors++; $display("[TB] FAIL midreset_count: got %0d expected 1", got_cnt); end
        checks++; if (got_data[0] !== 74'd25) begin errors++; $display("[TB] FAIL midreset_acc: got %0d expected 25", got_data[0]); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; mode = 2'b00; acc_clr = 1'b0;
        in1 = '0; in2 = '0; out_ready = 1'b1;
        test_reset();
        test_dual();
        test_mul27();
        test_quad();
        test_back_to_back_mac();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_mult_pipe.md
Name: dsp_mult_pipe

Overview:
- Parametrised, pipelined successor to the combinational mode-configurable DSP multiplier.
- Supports four modes:
  - dual 19x18 multiply
  - single 27x27 multiply
  - quad 9x9 multiply
  - 27x27 multiply-accumulate
- Valid/ready handshake on both sides, configurable latency, and per-transaction mode.
- Sits between the operand-fetch logic and the result bus of the DSP slice.

Parameters:
- LATENCY, 3, number of register stages from input accept to out_valid; legal range 1..4.
- ACC_W, 74, accumulator width in bits; must be >= 74. OUT_W = ACC_W.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block can accept a transaction this cycle.
- mode  input  2  00 dual 19x18; 01 27x27; 10 quad 9x9; 11 27x27 MAC.
- acc_clr  input  1  mode 11 only: start a new accumulation with this product.
- IN1  input  37  operand word 1.
- IN2  input  37  operand word 2.
- out_valid  output  1  result present on out_data.
- out_ready  input  1  downstream accepts the result.
- out_data  output  ACC_W  result.
- out_mode  output  2  mode of the presented result.

Behaviour:
- Reset (rst=1 at a clock edge) has priority over everything else, including mid-operation reset:
  - out_valid=0, out_data=0, out_mode=00, accumulator=0.
  - All stage-valid bits are cleared, so in-flight transactions are discarded.
  - in_ready=1 from the first cycle after reset.
- Transfers:
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stall: global pipeline enable en = !(out_valid && !out_ready).
  - in_ready = en (combinational).
  - When en=0, every stage holds its data, mode and valid bit.
  - A bubble stage (valid=0) is still overwritten when en=1.
- Latency: an accepted transaction appears with out_valid=1 exactly LATENCY cycles later when unstalled. Throughput is 1 transaction per cycle.
- mode and acc_clr are captured with the operands and travel with them. Mode may change every cycle with no flush.
- Products are unsigned. Results are zero-extended into out_data; unused upper bits are 0.
- Mode 00:
  - P1 = IN1[18:0]*IN1[36:19], P2 = IN2[18:0]*IN2[36:19] (37 bits each).
  - out_data[73:0] = {P2,P1}.
- Mode 01: out_data = IN1[26:0]*IN2[26:0] (54 bits).
- Mode 10:
  - out_data[17:0] = IN1[8:0]*IN1[17:9]
  - out_data[35:18] = IN1[26:18]*IN1[35:27]
  - out_data[53:36] = IN2[8:0]*IN2[17:9]
  - out_data[71:54] = IN2[26:18]*IN2[35:27]
  - out_data[73:72] = 0. IN1[36] and IN2[36] are ignored.
- Mode 11: P = IN1[26:0]*IN2[26:0].
  - Accumulator update happens when the transaction advances into the output register:
    - acc_clr=1: acc <= P.
    - acc_clr=0: acc <= acc + P, wrapping modulo 2^ACC_W.
  - out_data shows the updated accumulator.
  - Back-to-back MAC transactions chain with no gap.
  - Non-MAC transactions neither read nor modify the accumulator.
- Simultaneous events:
  - An output transfer and a new result arriving in the same cycle is legal; out_valid stays 1 and the data is replaced.
  - Accept during a stall is impossible, because in_ready=0.
- Partial products are built from 9x9 and 10x9 primitives summed in stage 1. Additional stages are pure pipeline registers. For LATENCY=1, the sum and accumulate occur in the single stage.

Test Plan:
- Mode 00, LATENCY=3, out_ready=1:
  - Stimulus: IN1={18'd3,19'd5}, IN2={18'd2,19'd7}.
  - Response: out_valid 3 cycles after accept; out_data=(14<<37)|15; out_mode=00.
- Mode 01:
  - Stimulus: IN1[26:0]=IN2[26:0]=27'h7FFFFFF.
  - Response: out_data = 2^54 - 2^28 + 1.
- Mode 10:
  - Stimulus: operand pairs (3,4), (5,6), (7,8), (9,10).
  - Response: fields read 12, 30, 56, 90; bits [73:72]=0.
- Mode 11, back-to-back:
  - Stimulus: (10,10,clr=1), (20,3,clr=0), a mode-01 (2,2) interleaved, then (1,1,clr=1).
  - Response: outputs 100, 160, 4, 1 in order; accumulator unaffected by the mode-01 transaction.
- Stall:
  - Stimulus: 3 transactions in flight, out_ready=0 for 5 cycles.
  - Response: in_ready=0 while the head result is held; out_data stable; all 3 results delivered in order afterwards with no loss or duplication.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle with 2 MAC transactions in flight.
  - Response: next cycle out_valid=0 and out_data=0. A following (5,5,clr=0) outputs 25, proving the accumulator was cleared.
